axi_read_master: RTL and testbench

AXI4 read initiator that drives the read address/data channels of an AXI slave such as axi_dut. It accepts simple read commands (word address plus beat count) and issues INCR bursts, splitting any command that crosses a 4 KB boundary. Read data is returned on a ready/valid stream toward the requester. Only one burst is outstanding at a time. The ar lock/cache/prot inputs of the slave are tied to 0 at integration and are not ports of this block.

---
 rtl/axi_pkg.sv | 27 ++
 rtl/axi_burst_split.sv | 41 ++++
 rtl/axi_read_master.sv | 190 +++++++++++++++++++
 tb/tb_axi_read_master.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst and response codes, read-master states,
// and the 4 KB page size that bursts may not cross.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned BOUNDARY_4K = 32'd4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        DATA = 2'd2
    } rd_state_e;

    // An error response is any code with the upper bit set (SLVERR/DECERR).
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_burst_split.sv
// Splits a read command into at most two INCR bursts so that no burst
// crosses a 4 KB page. Purely combinational.
module axi_burst_split
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 2
)(
    input  logic [ADDR_W-1:0] i_addr,        // word-aligned start address
    input  logic [8:0]        i_total,       // total beats, 1..256
    output logic [7:0]        o_first_len,   // first burst beats minus 1
    output logic              o_has_second,
    output logic [ADDR_W-1:0] o_second_addr, // next page start
    output logic [7:0]        o_second_len   // second burst beats minus 1
);

    localparam int HI_W = ADDR_W - 12;

    logic [12:0]     w_to_bnd;
    logic [8:0]      w_first;
    logic [8:0]      w_rem;
    logic [HI_W-1:0] w_page_next;

    // Beats left before the page boundary, first burst size and remainder.
    always_comb begin
        w_to_bnd    = (13'(BOUNDARY_4K) - {1'b0, i_addr[11:0]}) >> SIZE_W;
        if (w_to_bnd > {4'd0, i_total}) begin
            w_first = i_total;
        end else begin
            w_first = w_to_bnd[8:0];
        end
        w_rem       = i_total - w_first;
        w_page_next = i_addr[ADDR_W-1:12] + HI_W'(1);
    end

    assign o_first_len   = 8'(w_first - 9'd1);
    assign o_has_second  = (w_rem != 9'd0);
    assign o_second_addr = {w_page_next, 12'd0};
    assign o_second_len  = 8'(w_rem - 9'd1);

endmodule

// File: rtl/axi_read_master.sv
// AXI4 read initiator: accepts (address, beat count) commands, issues one or
// two INCR bursts (split at 4 KB), and passes read beats straight through to
// a ready/valid requester stream. One burst outstanding at a time.
module axi_read_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter logic [ID_W-1:0] ID_VAL = {ID_W{1'b0}}
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    output logic [DATA_W-1:0] dout_data,
    output logic              dout_last,
    output logic              dout_err,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam int SIZE_W = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'((32'd1 << SIZE_W) - 32'd1));

    rd_state_e         r_state;
    rd_state_e         w_next;

    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_addr2;
    logic [7:0]        r_len2;
    logic              r_has2;
    logic [7:0]        r_beat_cnt;

    logic [ADDR_W-1:0] w_addr_al;
    logic [8:0]        w_total;
    logic [7:0]        w_first_len;
    logic              w_has2;
    logic [ADDR_W-1:0] w_addr2;
    logic [7:0]        w_len2;
    logic              w_in_data;
    logic              w_beat;
    logic              w_burst_last;
    logic              w_ar_hs;

    assign w_addr_al = cmd_addr & ADDR_MASK;
    assign w_total   = {1'b0, cmd_len} + 9'd1;

    axi_burst_split #(
        .ADDR_W (ADDR_W),
        .SIZE_W (SIZE_W)
    ) u_split (
        .i_addr        (w_addr_al),
        .i_total       (w_total),
        .o_first_len   (w_first_len),
        .o_has_second  (w_has2),
        .o_second_addr (w_addr2),
        .o_second_len  (w_len2)
    );

    assign w_in_data    = (r_state == DATA);
    assign w_beat       = w_in_data && rvalid && dout_ready;
    assign w_burst_last = (r_beat_cnt == r_arlen);
    assign w_ar_hs      = r_arvalid && arready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_next = AR;
                end else begin
                    w_next = IDLE;
                end
            end
            AR: begin
                if (w_ar_hs) begin
                    w_next = DATA;
                end else begin
                    w_next = AR;
                end
            end
            DATA: begin
                if (w_beat && w_burst_last) begin
                    w_next = r_has2 ? AR : IDLE;
                end else begin
                    w_next = DATA;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Command capture, AR channel registers and per-burst beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_araddr   <= {ADDR_W{1'b0}};
            r_arlen    <= 8'd0;
            r_arvalid  <= 1'b0;
            r_addr2    <= {ADDR_W{1'b0}};
            r_len2     <= 8'd0;
            r_has2     <= 1'b0;
            r_beat_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_araddr   <= w_addr_al;
                        r_arlen    <= w_first_len;
                        r_has2     <= w_has2;
                        r_addr2    <= w_addr2;
                        r_len2     <= w_len2;
                        r_arvalid  <= 1'b1;
                        r_beat_cnt <= 8'd0;
                    end
                end
                AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        if (w_burst_last) begin
                            r_beat_cnt <= 8'd0;
                            if (r_has2) begin
                                // Second half of a split command.
                                r_araddr  <= r_addr2;
                                r_arlen   <= r_len2;
                                r_has2    <= 1'b0;
                                r_arvalid <= 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Requester-side stream: zero-latency pass-through while in DATA.
    always_comb begin
        cmd_ready  = (r_state == IDLE);
        rready     = w_in_data && dout_ready;
        dout_valid = w_in_data && rvalid;
        dout_data  = rdata;
        dout_last  = w_in_data && rvalid && w_burst_last && !r_has2;
        dout_err   = w_in_data && rvalid &&
                     (resp_is_err(rresp) || (rid != ID_VAL) || (rlast != w_burst_last));
    end

    assign arid    = ID_VAL;
    assign araddr  = r_araddr;
    assign arlen   = r_arlen;
    assign arsize  = 3'(SIZE_W);
    assign arburst = BURST_INCR;
    assign arvalid = r_arvalid;

endmodule

// File: tb/tb_axi_read_master.sv
// Randomised scoreboard bench for axi_read_master with a behavioural AXI slave.
module tb_axi_read_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam logic [ID_W-1:0] ID_VAL = 4'd0;

    logic              clk, rst;
    logic              cmd_valid, cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last, dout_err, dout_valid, dout_ready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid, arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, rready;

    axi_read_master #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .ID_W (ID_W), .ID_VAL (ID_VAL)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
        .cmd_addr (cmd_addr), .cmd_len (cmd_len),
        .dout_data (dout_data), .dout_last (dout_last), .dout_err (dout_err),
        .dout_valid (dout_valid), .dout_ready (dout_ready),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize),
        .arburst (arburst), .arvalid (arvalid), .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast),
        .rvalid (rvalid), .rready (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [31:0] data; logic last; logic err; } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    ar_t   slv_q[$];

    int checks = 0;
    int passed = 0;

    // Bench control shared between processes.
    logic        in_reset;
    int          rdy_mode;     // 0: always ready, 1: toggle, 2: random
    int          stall_cnt;
    int          err_kind;     // -1 none, 0 SLVERR, 1 bad rid, 2 wrong rlast
    logic [31:0] err_addr;
    int          beats_seen;

    // Slave state.
    logic        s_active;
    logic [31:0] s_addr;
    int          s_len, s_beat;
    logic        r_hs;

    // Monitor state.
    logic        prev_wait;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic        idle_next;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Reference model: burst list and beat list from plain page arithmetic.
    task automatic model_push(input logic [31:0] a_in, input int len);
        int unsigned a, total, to_bnd, first;
        ar_t   t;
        beat_t b;
        a      = a_in & ~32'd3;
        total  = len + 1;
        to_bnd = (4096 - (a % 4096)) / 4;
        first  = (total < to_bnd) ? total : to_bnd;
        t.addr = a;
        t.len  = 8'(first - 1);
        exp_ar.push_back(t);
        if (total > first) begin
            t.addr = (a / 4096 + 1) * 4096;
            t.len  = 8'(total - first - 1);
            exp_ar.push_back(t);
        end
        for (int i = 0; i < int'(total); i++) begin
            logic [31:0] ba;
            ba     = a + 32'(4 * i);
            b.data = data_of(ba);
            b.last = (i == int'(total) - 1);
            b.err  = (err_kind >= 0) && (ba == err_addr);
            exp_beat.push_back(b);
        end
    endtask

    // Monitor: sample everything on the falling edge, pop and compare.
    always @(negedge clk) begin
        if (!in_reset) begin
            if (idle_next) begin
                check("idle_after_last", cmd_ready, 1);
                idle_next = 1'b0;
            end
            if (arvalid) begin
                check("cmd_ready_in_ar", cmd_ready, 0);
                if (prev_wait) begin
                    check("ar_addr_stable", araddr, prev_addr);
                    check("ar_len_stable", arlen, prev_len);
                end
                if (arready) begin
                    ar_t t, e;
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", 1, 0);
                    end else begin
                        e = exp_ar.pop_front();
                        check("ar_addr", araddr, e.addr);
                        check("ar_len", arlen, e.len);
                    end
                    check("ar_size", arsize, 2);
                    check("ar_burst", arburst, 1);
                    check("ar_id", arid, ID_VAL);
                    t.addr = araddr;
                    t.len  = arlen;
                    slv_q.push_back(t);
                    prev_wait = 1'b0;
                end else begin
                    prev_wait = 1'b1;
                    prev_addr = araddr;
                    prev_len  = arlen;
                end
            end else begin
                prev_wait = 1'b0;
            end
            if (s_active) begin
                check("rready_mirror", rready, dout_ready);
                check("dout_valid_mirror", dout_valid, rvalid);
            end else begin
                check("rready_idle", rready, 0);
                check("dout_valid_idle", dout_valid, 0);
            end
            if (rvalid && rready) r_hs = 1'b1;
            if (dout_valid && dout_ready) begin
                beat_t e;
                beats_seen++;
                if (exp_beat.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    e = exp_beat.pop_front();
                    check("dout_data", dout_data, e.data);
                    check("dout_last", dout_last, e.last);
                    check("dout_err", dout_err, e.err);
                end
                if (dout_last) idle_next = 1'b1;
            end
        end
    end

    // Slave and requester driver: update on the rising edge, drive 1 later.
    always @(posedge clk) begin
        if (in_reset) begin
            s_active = 1'b0;
            r_hs     = 1'b0;
        end else begin
            if (r_hs) begin
                r_hs = 1'b0;
                s_beat++;
                if (s_beat > s_len) s_active = 1'b0;
            end
            if (!s_active && slv_q.size() > 0) begin
                ar_t t;
                t        = slv_q.pop_front();
                s_addr   = t.addr;
                s_len    = int'(t.len);
                s_beat   = 0;
                s_active = 1'b1;
            end
        end
        #1;
        if (stall_cnt > 0 && arvalid) begin
            arready = 1'b0;
            stall_cnt--;
        end else begin
            arready = ($urandom_range(0, 3) != 0);
        end
        if (in_reset || !s_active) begin
            rvalid = 1'b0;
            rresp  = 2'b00;
            rid    = ID_VAL;
            rlast  = 1'b0;
        end else begin
            logic [31:0] ba;
            logic        hit;
            ba     = s_addr + 32'(4 * s_beat);
            hit    = (ba == err_addr);
            rvalid = ($urandom_range(0, 3) != 0);
            rdata  = data_of(ba);
            rresp  = (err_kind == 0 && hit) ? 2'b10 : 2'b00;
            rid    = (err_kind == 1 && hit) ? ID_VAL + 4'd1 : ID_VAL;
            rlast  = (s_beat == s_len) ^ (err_kind == 2 && hit);
        end
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            default: dout_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic send(input logic [31:0] a, input int len);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
        end else begin
            model_push(a, len);
            cmd_valid = 1'b1;
            cmd_addr  = a;
            cmd_len   = 8'(len);
            @(posedge clk); #2;
            cmd_valid = 1'b0;
            check("cmd_ready_after_accept", cmd_ready, 0);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_beat.size() != 0 || exp_ar.size() != 0) && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        if (exp_beat.size() != 0 || exp_ar.size() != 0) begin
            check("cmd_complete_timeout", exp_beat.size(), 0);
            exp_beat.delete();
            exp_ar.delete();
        end
        @(posedge clk); #2;
        err_kind = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_reset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
        dout_ready = 1'b1; arready = 1'b0; rvalid = 1'b0;
        rid = ID_VAL; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
        rdy_mode = 0; stall_cnt = 0; err_kind = -1; err_addr = 32'hFFFF_FFFF;
        beats_seen = 0; s_active = 1'b0; s_addr = 32'd0; s_len = 0; s_beat = 0;
        r_hs = 1'b0; prev_wait = 1'b0; prev_addr = 32'd0; prev_len = 8'd0; idle_next = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        rst = 1'b1; in_reset = 1'b0;

        // Directed cases.
        send(32'h103, 3);  wait_done();
        send(32'hFF8, 3);  wait_done();
        rdy_mode = 1;
        send(32'h400, 7);  wait_done();
        rdy_mode = 0;
        err_kind = 0; err_addr = 32'h504;
        send(32'h500, 3);  wait_done();
        err_kind = 1; err_addr = 32'h600;
        send(32'h600, 3);  wait_done();
        err_kind = 2; err_addr = 32'h1FFC;
        send(32'h1FF8, 3); wait_done();
        stall_cnt = 10;
        send(32'h700, 3);  wait_done();
        check("stall_consumed", stall_cnt, 0);

        // Reset in the middle of a burst.
        begin
            int bs, n;
            bs = beats_seen;
            n  = 0;
            send(32'h300, 3);
            while (beats_seen < bs + 1 && n < 500) begin
                @(posedge clk);
                n++;
            end
            check("reset_test_first_beat", beats_seen >= bs + 1, 1);
            #3;
            rst = 1'b0; in_reset = 1'b1;
            #1;
            check("midrst_arvalid", arvalid, 0);
            check("midrst_rready", rready, 0);
            check("midrst_dout_valid", dout_valid, 0);
            exp_ar.delete(); exp_beat.delete(); slv_q.delete();
            s_active = 1'b0; r_hs = 1'b0; prev_wait = 1'b0; idle_next = 1'b0;
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b1; in_reset = 1'b0;
            check("postrst_cmd_ready", cmd_ready, 1);
            send(32'h200, 0); wait_done();
        end

        // Randomised commands around page boundaries.
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            int          len;
            int unsigned off;
            off = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095)
                                               : 4096 - $urandom_range(1, 64);
            a   = ($urandom_range(0, 255) << 12) | off;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                err_kind = $urandom_range(0, 2);
                err_addr = (a & ~32'd3) + 32'(4 * $urandom_range(0, len));
            end else begin
                err_kind = -1;
            end
            if ($urandom_range(0, 4) == 0) stall_cnt = $urandom_range(1, 12);
            send(a, len);
            wait_done();
        end

        check("exp_ar_empty", exp_ar.size(), 0);
        check("exp_beat_empty", exp_beat.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
